gb_host_arbiter: RTL and testbench
==================================

Name: gb_host_arbiter

Overview:
- Shares one ghostbus host port between NREQ independent requesters, for example a UART bridge and a local sequencer.
- Each requester issues single-word read or write transactions through a valid/ready handshake.
- Fair round-robin arbitration; one transaction in flight at a time.
- Drives the top-level ghostbus ports (gb_addr, gb_wdata, gb_wen, gb_rstb), captures gb_rdata after a fixed read latency and returns it to the owning requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 24, ghostbus address width.
- DW, 32, ghostbus data width.
- READ_DELAY, 2, cycles from the gb_rstb strobe to valid gb_rdata (1..15).

Ports:
- gb_clk  in  1  single clock for the block and the bus.
- gb_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester transaction request.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses [(i+1)*AW-1 -: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot read-data-valid pulse.
- rsp_rdata  out  DW  read data, shared by all requesters; qualified by rsp_valid.
- gb_addr  out  AW  bus address.
- gb_wdata  out  DW  bus write data.
- gb_wen  out  1  write enable/strobe.
- gb_rstb  out  1  read strobe.
- gb_rdata  in  DW  bus read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous assert, all outputs and state):
  - gb_addr=0, gb_wdata=0, gb_wen=0, gb_rstb=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - state=IDLE; round-robin pointer=0 (requester 0 highest priority).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Register that requester's addr, wdata and write onto gb_addr/gb_wdata.
  - Next state ISSUE. ptr <= grant+1 (mod NREQ).
- ISSUE (exactly 1 cycle):
  - req_ready[grant]=1.
  - Write: gb_wen=1, next state IDLE.
  - Read: gb_rstb=1, counter=READ_DELAY-1, next state WAIT.
- WAIT:
  - gb_addr held stable; gb_wen=0, gb_rstb=0.
  - Decrement counter; at 0 capture gb_rdata into rsp_rdata and go to RESP.
  - Capture therefore occurs in the cycle that is READ_DELAY cycles after the strobe.
- RESP (1 cycle): rsp_valid[grant]=1; next state IDLE.
- Latency: req_valid seen in IDLE at cycle T gives ISSUE/req_ready at T+1.
  - Write completes at T+1; the next grant can issue at T+3.
  - Read: rsp_valid at T+2+READ_DELAY.
- Requester rules:
  - A requester holds valid and its fields stable until it sees req_ready.
  - Deasserting valid before ready is legal; it is sampled only in IDLE.
  - Arbiter inputs are ignored outside IDLE.
- gb_wdata is driven for reads too (the registered value is don't-care to the bus).
- At most one bit of req_ready/rsp_valid is set per cycle.
- gb_wen and gb_rstb are never high together.
- A requester whose valid stays asserted after ready is treated as a new request on its next grant.
- Reset mid-transaction: the in-flight read is dropped, no rsp_valid is issued, and ptr returns to 0.
- NREQ=1 degenerates to a pass-through sequencer with the same timing.

Test Plan:
- Write: req0 writes addr 0x000001, data 0xE at T -> gb_wen=1 with gb_addr=0x000001 and gb_wdata=0xE at T+1 only; req_ready=2'b01 at T+1.
- Read, READ_DELAY=2: bus model returns 0x42 two cycles after gb_rstb; req1 reads addr 0x000000 -> gb_rstb pulse at T+1, rsp_valid=2'b10 with rsp_rdata=0x42 at T+4.
- Fairness: both requesters hold valid continuously with writes -> grants alternate 0,1,0,1; neither is granted twice in a row.
- Contention during a read: req1 asserts valid while req0's read is in WAIT -> req1 is not granted until after RESP; gb_addr stays stable throughout WAIT.
- Reset in WAIT: assert gb_rst one cycle -> all outputs 0 immediately; no rsp_valid after release; the next simultaneous request grants req0.
- Back-to-back writes: 8 writes from a single requester -> one gb_wen pulse every 2 cycles, with addresses in order.

Source files
------------

// File: rtl/gb_host_arbiter_if.sv
// Requester-side handshake and ghostbus host signals for gb_host_arbiter.
// The master modport is the arbiter; the slave modport is the surrounding requesters and bus.
interface gb_host_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 24,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      gb_addr;
  logic [DW-1:0]      gb_wdata;
  logic               gb_wen;
  logic               gb_rstb;
  logic [DW-1:0]      gb_rdata;
  logic               busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, gb_rdata,
    output req_ready, rsp_valid, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, gb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb, busy
  );
endinterface

// File: rtl/gb_host_arbiter.sv
// Round-robin arbiter sharing one ghostbus host port between NREQ requesters,
// one single-word transaction in flight at a time.
module gb_host_arbiter #(
  parameter int NREQ       = 2,
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 2
) (
  input logic              gb_clk,
  input logic              gb_rst,
  gb_host_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   pick_next;
  logic            pick_found;
  int unsigned     idx;

  logic            write_r;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [DW-1:0]   rdata_r;

  logic [NREQ-1:0] ready_c;
  logic [NREQ-1:0] rsp_c;
  logic            wen_c;
  logic            rstb_c;
  logic            busy_c;

  // First valid requester searching upward from ptr, wrapping modulo NREQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!pick_found && bus.req_valid[PW'(idx)]) begin
        pick       = PW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (int'(pick) == NREQ - 1) pick_next = '0;
    else                        pick_next = pick + 1'b1;
  end

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = write_r ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c = '0;
    rsp_c   = '0;
    wen_c   = 1'b0;
    rstb_c  = 1'b0;
    busy_c  = (state != IDLE);
    case (state)
      ISSUE: begin
        ready_c[grant] = 1'b1;
        wen_c          = write_r;
        rstb_c         = !write_r;
      end
      RESP:    rsp_c[grant] = 1'b1;
      default: ;
    endcase
  end

  // Request fields are latched only on a grant; the bus address then stays
  // stable through WAIT and RESP until the next grant.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      ptr     <= '0;
      grant   <= '0;
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt     <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant   <= pick;
            ptr     <= pick_next;
            write_r <= bus.req_write[pick];
            addr_r  <= bus.req_addr[int'(pick)*AW +: AW];
            wdata_r <= bus.req_wdata[int'(pick)*DW +: DW];
          end
        end
        ISSUE: begin
          if (!write_r) cnt <= CW'(READ_DELAY - 1);
        end
        WAIT: begin
          if (cnt == '0) rdata_r <= bus.gb_rdata;
          else           cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gb_addr   = addr_r;
  assign bus.gb_wdata  = wdata_r;
  assign bus.gb_wen    = wen_c;
  assign bus.gb_rstb   = rstb_c;
  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_c;
  assign bus.rsp_rdata = rdata_r;
  assign bus.busy      = busy_c;

  a_strobe_excl: assert property (@(posedge gb_clk) disable iff (gb_rst)
    !(bus.gb_wen && bus.gb_rstb));
  a_ready_onehot: assert property (@(posedge gb_clk) disable iff (gb_rst)
    $onehot0(bus.req_ready));
  a_rsp_onehot: assert property (@(posedge gb_clk) disable iff (gb_rst)
    $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_gb_host_arbiter.sv
// Scoreboard bench for gb_host_arbiter: expected bus/response events are queued
// when a request is driven and popped when the arbiter produces them.
module tb_gb_host_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int RD   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] v = '0;
  logic [NREQ-1:0] w = '0;
  logic [AW-1:0]   a [NREQ];
  logic [DW-1:0]   d [NREQ];

  gb_host_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  gb_host_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .READ_DELAY(RD)) dut (
    .gb_clk (clk),
    .gb_rst (rst),
    .bus    (bus)
  );

  assign bus.req_valid = v;
  assign bus.req_write = w;
  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_addr[i*AW +: AW]  = a[i];
    assign bus.req_wdata[i*DW +: DW] = d[i];
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] ad);
    return (ad == '0) ? 32'h0000_0042 : {8'hA5, ad};
  endfunction

  // Bus model: read data appears RD cycles after the strobe, garbage otherwise.
  logic [RD-1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[RD-2:0], bus.gb_rstb};
  assign bus.gb_rdata = rd_pipe[RD-1] ? mem_word(bus.gb_addr) : 32'hDEAD_BEEF;

  logic [AW+2*DW+2*NREQ+2:0] all_out;
  assign all_out = {bus.gb_addr, bus.gb_wdata, bus.gb_wen, bus.gb_rstb, bus.req_ready,
                    bus.rsp_valid, bus.rsp_rdata, bus.busy};

  typedef struct {
    bit             is_rd;
    int unsigned    req;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v = '0;
    w = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ready=%b expected busy=0 ready=00", bus.busy, bus.req_ready);
    end
  endtask

  task automatic test_write();
    tick();
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 24'h000001; d[0] = 32'hE;
    q.push_back('{is_rd: 1'b0, req: 0, addr: 24'h000001, data: 32'hE});
    @(negedge clk);
    checks++;
    if (bus.gb_wen !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL write_early: got wen=%b ready=%b expected wen=0 ready=00", bus.gb_wen, bus.req_ready);
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.gb_wen !== 1'b1 || bus.gb_rstb !== 1'b0 || bus.gb_addr !== e.addr ||
        bus.gb_wdata !== e.data || bus.req_ready !== NREQ'(1 << e.req)) begin
      errors++;
      $display("FAIL write_issue: got wen=%b rstb=%b addr=%h wdata=%h ready=%b expected wen=1 rstb=0 addr=%h wdata=%h ready=%b",
               bus.gb_wen, bus.gb_rstb, bus.gb_addr, bus.gb_wdata, bus.req_ready, e.addr, e.data, NREQ'(1 << e.req));
    end
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gb_wen !== 1'b0 || bus.req_ready !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_after: got wen=%b ready=%b busy=%b expected 0 00 0", bus.gb_wen, bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_read();
    tick();
    v[1] = 1'b1; w[1] = 1'b0; a[1] = 24'h000000;
    q.push_back('{is_rd: 1'b1, req: 1, addr: 24'h000000, data: 32'h42});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.gb_rstb !== 1'b1 || bus.gb_wen !== 1'b0 || bus.req_ready !== 2'b10 || bus.gb_addr !== '0) begin
      errors++;
      $display("FAIL read_issue: got rstb=%b wen=%b ready=%b addr=%h expected 1 0 10 000000",
               bus.gb_rstb, bus.gb_wen, bus.req_ready, bus.gb_addr);
    end
    tick();
    v[1] = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gb_rstb !== 1'b0 || bus.rsp_valid !== '0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL read_wait_c%0d: got rstb=%b rsp_valid=%b busy=%b expected 0 00 1",
                 c, bus.gb_rstb, bus.rsp_valid, bus.busy);
      end
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.rsp_valid !== NREQ'(1 << e.req) || bus.rsp_rdata !== e.data) begin
      errors++;
      $display("FAIL read_rsp: got rsp_valid=%b rdata=%h expected %b %h",
               bus.rsp_valid, bus.rsp_rdata, NREQ'(1 << e.req), e.data);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done: got rsp_valid=%b busy=%b expected 00 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_fairness();
    int unsigned cnt [NREQ];
    int last;
    int gi;
    int budget;
    for (int n = 0; n < 8; n++) begin
      e.is_rd = 1'b0;
      e.req   = n % 2;
      e.addr  = ((e.req == 1) ? 24'h000200 : 24'h000100) + AW'(n / 2);
      e.data  = 32'hF000_0000 | DW'(e.req << 8) | DW'(n / 2);
      q.push_back(e);
    end
    tick();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    v = 2'b11; w = 2'b11;
    a[0] = 24'h000100; a[1] = 24'h000200;
    d[0] = 32'hF000_0000; d[1] = 32'hF000_0100;
    last = -1;
    budget = 0;
    while (q.size() > 0 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (bus.gb_wen === 1'b1) begin
        e = q.pop_front();
        gi = (bus.req_ready === 2'b10) ? 1 : 0;
        checks++;
        if (bus.req_ready !== NREQ'(1 << e.req) || bus.gb_addr !== e.addr || bus.gb_wdata !== e.data) begin
          errors++;
          $display("FAIL fair_grant: got ready=%b addr=%h wdata=%h expected %b %h %h",
                   bus.req_ready, bus.gb_addr, bus.gb_wdata, NREQ'(1 << e.req), e.addr, e.data);
        end
        checks++;
        if (gi == last) begin
          errors++;
          $display("FAIL fair_repeat: got requester %0d granted twice in a row, expected alternation", gi);
        end
        last = gi;
        tick();
        cnt[gi]++;
        a[gi] = ((gi == 1) ? 24'h000200 : 24'h000100) + AW'(cnt[gi]);
        d[gi] = 32'hF000_0000 | DW'(gi << 8) | DW'(cnt[gi]);
        if (cnt[gi] == 4) v[gi] = 1'b0;
      end
    end
    v = '0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL fair_timeout: got %0d grants outstanding expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    q.push_back('{is_rd: 1'b1, req: 0, addr: 24'h000010, data: mem_word(24'h000010)});
    q.push_back('{is_rd: 1'b0, req: 1, addr: 24'h000020, data: 32'h55});
    tick();
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 24'h000010;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.gb_rstb !== 1'b1 || bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL cont_issue: got rstb=%b ready=%b expected 1 01", bus.gb_rstb, bus.req_ready);
    end
    tick();
    v[0] = 1'b0;
    v[1] = 1'b1; w[1] = 1'b1; a[1] = 24'h000020; d[1] = 32'h55;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== '0 || bus.gb_wen !== 1'b0 || bus.gb_addr !== 24'h000010 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_wait_c%0d: got ready=%b wen=%b addr=%h busy=%b expected 00 0 000010 1",
                 c, bus.req_ready, bus.gb_wen, bus.gb_addr, bus.busy);
      end
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== e.data || bus.req_ready !== '0 || bus.gb_addr !== e.addr) begin
      errors++;
      $display("FAIL cont_rsp: got rsp_valid=%b rdata=%h ready=%b addr=%h expected 01 %h 00 %h",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.gb_addr, e.data, e.addr);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.gb_wen !== 1'b0) begin
      errors++;
      $display("FAIL cont_idle: got ready=%b wen=%b expected 00 0", bus.req_ready, bus.gb_wen);
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.gb_wen !== 1'b1 || bus.req_ready !== 2'b10 || bus.gb_addr !== e.addr || bus.gb_wdata !== e.data) begin
      errors++;
      $display("FAIL cont_second: got wen=%b ready=%b addr=%h wdata=%h expected 1 10 %h %h",
               bus.gb_wen, bus.req_ready, bus.gb_addr, bus.gb_wdata, e.addr, e.data);
    end
    tick();
    v[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_wait();
    tick();
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 24'h000033;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.gb_rstb !== 1'b1 || bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstw_issue: got rstb=%b ready=%b expected 1 01", bus.gb_rstb, bus.req_ready);
    end
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL rstw_async: got %h expected 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== '0 || bus.busy !== 1'b0 || bus.rsp_rdata !== '0) begin
        errors++;
        $display("FAIL rstw_drop_c%0d: got rsp_valid=%b busy=%b rdata=%h expected 00 0 0",
                 c, bus.rsp_valid, bus.busy, bus.rsp_rdata);
      end
    end
    q.push_back('{is_rd: 1'b0, req: 0, addr: 24'h000050, data: 32'h5050});
    q.push_back('{is_rd: 1'b0, req: 1, addr: 24'h000060, data: 32'h6060});
    tick();
    v = 2'b11; w = 2'b11;
    a[0] = 24'h000050; d[0] = 32'h5050;
    a[1] = 24'h000060; d[1] = 32'h6060;
    @(negedge clk);
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.gb_wen !== 1'b1 || bus.req_ready !== NREQ'(1 << e.req) || bus.gb_addr !== e.addr) begin
      errors++;
      $display("FAIL rstw_ptr: got wen=%b ready=%b addr=%h expected 1 %b %h",
               bus.gb_wen, bus.req_ready, bus.gb_addr, NREQ'(1 << e.req), e.addr);
    end
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus.gb_wen !== 1'b1 || bus.req_ready !== NREQ'(1 << e.req) || bus.gb_addr !== e.addr) begin
      errors++;
      $display("FAIL rstw_next: got wen=%b ready=%b addr=%h expected 1 %b %h",
               bus.gb_wen, bus.req_ready, bus.gb_addr, NREQ'(1 << e.req), e.addr);
    end
    tick();
    v[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    int cyc;
    int last_cyc;
    for (int n = 0; n < 8; n++)
      q.push_back('{is_rd: 1'b0, req: 0, addr: 24'h000400 + AW'(n), data: DW'(n) * 32'h11});
    tick();
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 24'h000400; d[0] = '0;
    k = 0;
    cyc = 0;
    last_cyc = -1;
    while (q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.gb_wen === 1'b1) begin
        e = q.pop_front();
        checks++;
        if (bus.gb_addr !== e.addr || bus.gb_wdata !== e.data || bus.req_ready !== 2'b01) begin
          errors++;
          $display("FAIL b2b_write%0d: got addr=%h wdata=%h ready=%b expected %h %h 01",
                   k, bus.gb_addr, bus.gb_wdata, bus.req_ready, e.addr, e.data);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d cycles between strobes expected 2", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        tick();
        k++;
        if (k == 8) v[0] = 1'b0;
        else begin
          a[0] = 24'h000400 + AW'(k);
          d[0] = DW'(k) * 32'h11;
        end
      end
    end
    v[0] = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d writes outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.gb_wen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b wen=%b expected 0 0", bus.busy, bus.gb_wen);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_contention();
    test_reset_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
